// File: rtl/tpu_job_sequencer_if.sv
// Interface bundling the job-control, stream and TPU-port signals of tpu_job_sequencer.
//   master : sequencer side (drives busy/done, in_ready, out stream, TPU address/command/data)
//   slave  : environment side (host, DMA streams and the TPU memory-mapped port)
// Signals:
//   start, clear_c           job request and "zero C first" flag
//   busy, done               status; done is a one-cycle completion pulse
//   in_valid/in_ready/in_data           A then B rows
//   out_valid/out_ready/out_data/out_last  C half-rows, last on beat 15
//   tpu_addr/tpu_r_w/tpu_wdata/tpu_rdata   TPU port (rdata combinational from addr)
interface tpu_job_sequencer_if #(
    parameter int unsigned DATAW = 64,
    parameter int unsigned ADDRW = 16
);
    logic             start;
    logic             clear_c;
    logic             busy;
    logic             done;
    logic             in_valid;
    logic             in_ready;
    logic [DATAW-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [DATAW-1:0] out_data;
    logic             out_last;
    logic [ADDRW-1:0] tpu_addr;
    logic             tpu_r_w;
    logic [DATAW-1:0] tpu_wdata;
    logic [DATAW-1:0] tpu_rdata;

    modport master (
        input  start, clear_c, in_valid, in_data, out_ready, tpu_rdata,
        output busy, done, in_ready, out_valid, out_data, out_last,
               tpu_addr, tpu_r_w, tpu_wdata
    );

    modport slave (
        output start, clear_c, in_valid, in_data, out_ready, tpu_rdata,
        input  busy, done, in_ready, out_valid, out_data, out_last,
               tpu_addr, tpu_r_w, tpu_wdata
    );
endinterface

// File: rtl/tpu_job_sequencer.sv
// Host-side job sequencer for the 8x8 TPU core. Loads 8 A rows and 8 B rows from the
// input stream into the TPU, optionally zeroes C, issues the matmul start, waits out the
// systolic computation and streams the 16 C half-rows out.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : tpu_job_sequencer_if.master (job control, in/out streams, TPU port)
module tpu_job_sequencer #(
    parameter int unsigned DIM         = 8,
    parameter int unsigned DATAW       = 64,
    parameter int unsigned ADDRW       = 16,
    parameter int unsigned WAIT_CYCLES = 3 * DIM
) (
    input logic                 clk,
    input logic                 rst,
    tpu_job_sequencer_if.master bus
);

    localparam int unsigned WaitW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StClrC,
        StStart,
        StWait,
        StReadC,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic               clr_q, clr_d;

    // Page base in bits [15:8], beat index in bits [6:3] (8-byte stride).
    function automatic logic [ADDRW-1:0] beat_addr(input logic [7:0] page,
                                                   input logic [3:0] idx);
        return ADDRW'({page, 1'b0, idx, 3'b000});
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            wait_q  <= '0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            clr_q   <= clr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        wait_d        = wait_q;
        clr_d         = clr_q;
        bus.busy      = (state_q != StIdle);
        bus.done      = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_data  = bus.tpu_rdata;
        bus.tpu_addr  = '0;
        bus.tpu_r_w   = 1'b0;
        bus.tpu_wdata = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    clr_d   = bus.clear_c;
                    state_d = StLoadA;
                end
            end
            StLoadA, StLoadB: begin
                bus.in_ready  = 1'b1;
                bus.tpu_addr  = beat_addr((state_q == StLoadA) ? 8'h01 : 8'h02, idx_q);
                bus.tpu_wdata = bus.in_data;
                // The TPU write happens on the same edge as the stream handshake.
                bus.tpu_r_w   = bus.in_valid;
                if (bus.in_valid) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd7) begin
                        if (state_q == StLoadA) begin
                            state_d = StLoadB;
                        end else begin
                            state_d = clr_q ? StClrC : StStart;
                        end
                    end
                end
            end
            StClrC: begin
                bus.tpu_addr = beat_addr(8'h03, idx_q);
                bus.tpu_r_w  = 1'b1;
                idx_d        = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                bus.tpu_addr = ADDRW'(16'h0400);
                bus.tpu_r_w  = 1'b1;
                state_d      = StWait;
            end
            StWait: begin
                // C stays untouched until the whole compute window has elapsed.
                wait_d = wait_q + 1'b1;
                if (wait_q == WaitW'(WAIT_CYCLES - 1)) begin
                    state_d = StReadC;
                end
            end
            StReadC: begin
                // Address follows idx_q, so it holds while out_ready is low.
                bus.tpu_addr  = beat_addr(8'h03, idx_q);
                bus.out_valid = 1'b1;
                bus.out_last  = (idx_q == 4'd15);
                if (bus.out_ready) begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                bus.done = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Every state entry starts with fresh counters.
        if (state_d != state_q) begin
            idx_d  = '0;
            wait_d = '0;
        end
    end

endmodule

// File: tb/tb_tpu_job_sequencer.sv
// Self-checking bench for tpu_job_sequencer with a behavioural 8x8 TPU model
// (8-bit A/B elements, 16-bit accumulating C) behind the memory-mapped port.
module tb_tpu_job_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tpu_job_sequencer_if #(.DATAW(64), .ADDRW(16)) bus ();

    tpu_job_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- TPU model ----------------
    logic [63:0] a_mem [8];
    logic [63:0] b_mem [8];
    logic [15:0] c_mem [8][8];
    int          pend = 0;

    initial begin
        for (int i = 0; i < 8; i++) begin
            a_mem[i] = '0;
            b_mem[i] = '0;
            for (int j = 0; j < 8; j++) c_mem[i][j] = '0;
        end
    end

    always @(posedge clk) begin
        int s;
        if (bus.tpu_r_w) begin
            case (bus.tpu_addr[15:8])
                8'h01: a_mem[bus.tpu_addr[5:3]] <= bus.tpu_wdata;
                8'h02: b_mem[bus.tpu_addr[5:3]] <= bus.tpu_wdata;
                8'h03: for (int m = 0; m < 4; m++)
                    c_mem[bus.tpu_addr[6:4]][int'(bus.tpu_addr[3]) * 4 + m] <=
                        bus.tpu_wdata[16*m +: 16];
                8'h04: pend <= 23;
                default: ;
            endcase
        end
        // Result lands at the end of the 3*DIM-1 cycle compute window.
        if (pend > 0) begin
            pend <= pend - 1;
            if (pend == 1) begin
                for (int i = 0; i < 8; i++) begin
                    for (int j = 0; j < 8; j++) begin
                        s = 0;
                        for (int k = 0; k < 8; k++)
                            s += int'(a_mem[i][8*k +: 8]) * int'(b_mem[k][8*j +: 8]);
                        c_mem[i][j] <= c_mem[i][j] + 16'(s);
                    end
                end
            end
        end
    end

    always_comb begin
        bus.tpu_rdata = '0;
        if (bus.tpu_addr[15:8] == 8'h03) begin
            for (int m = 0; m < 4; m++)
                bus.tpu_rdata[16*m +: 16] =
                    c_mem[bus.tpu_addr[6:4]][int'(bus.tpu_addr[3]) * 4 + m];
        end
    end

    // ---------------- monitors ----------------
    logic [64:0] exp_q [$];
    logic [15:0] wr_log [$];
    int out_beats = 0;
    int done_cnt  = 0;
    int done_cyc  = 0;
    int start_wr  = 0;
    int early_acc = 0;

    always @(negedge clk) begin
        logic [64:0] e;
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                out_beats++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_beat", {63'd0, bus.out_valid}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", bus.out_data, e[63:0]);
                    chk("out_last", {63'd0, bus.out_last}, {63'd0, e[64]});
                end
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.tpu_r_w && (bus.tpu_addr[15:8] == 8'h01 || bus.tpu_addr[15:8] == 8'h02))
                wr_log.push_back(bus.tpu_addr);
            if (bus.tpu_r_w && bus.tpu_addr == 16'h0400) start_wr++;
            if (pend > 0 && bus.tpu_addr[15:8] == 8'h03) early_acc++;
        end
    end

    // ---------------- stimulus ----------------
    logic [63:0] a_rows [8];
    logic [63:0] b_rows [8];

    // Runs one job; stall_beat < 0 disables the out_ready stall, pulse injects start in WAIT.
    task automatic run_job(input bit clr, input bit toggle, input int stall_beat,
                           input int stall_len, input bit pulse, input int exp_lat,
                           input logic [63:0] exp_val);
        int beat_in    = 0;
        int stall_left = stall_len;
        int t          = 0;
        int d0         = done_cnt;
        int ob0        = out_beats;
        int start_cyc;
        logic [63:0] held;
        for (int i = 0; i < 16; i++) exp_q.push_back({(i == 15), exp_val});
        wr_log.delete();
        start_wr  = 0;
        early_acc = 0;
        bus.start   = 1'b1;
        bus.clear_c = clr;
        start_cyc   = cyc;
        @(posedge clk) #1;
        bus.start = 1'b0;
        while (done_cnt == d0 && t < 400) begin
            bus.start     = pulse && (t == 40);
            bus.in_valid  = (beat_in < 16) && (!toggle || (t % 2 == 1));
            bus.in_data   = (beat_in < 8) ? a_rows[beat_in % 8] : b_rows[beat_in % 8];
            bus.out_ready = !(stall_beat >= 0 && (out_beats - ob0) == stall_beat &&
                              stall_left > 0);
            @(negedge clk);
            if (t == 0) chk("busy_running", {63'd0, bus.busy}, 64'd1);
            if (bus.in_valid && bus.in_ready) beat_in++;
            if (bus.out_valid && !bus.out_ready) begin
                if (stall_left == stall_len) held = bus.out_data;
                chk("stall_addr", {48'd0, bus.tpu_addr}, 64'h0318);
                chk("stall_data", bus.out_data, held);
                stall_left--;
            end
            @(posedge clk) #1;
            t++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.start     = 1'b0;
        if (t >= 400) chk("job_timeout", 64'(t), 64'd0);
        chk("done_latency", 64'(done_cyc - start_cyc), 64'(exp_lat));
        @(negedge clk);
        @(negedge clk);
        chk("done_one_pulse", 64'(done_cnt - d0), 64'd1);
        chk("busy_after_done", {63'd0, bus.busy}, 64'd0);
        chk("beats_consumed", 64'(exp_q.size()), 64'd0);
        chk("one_start_write", 64'(start_wr), 64'd1);
        chk("no_early_c_access", 64'(early_acc), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            a_rows[i] = 64'd1 << (8 * i);
            b_rows[i] = 64'h0202_0202_0202_0202;
        end
        bus.start     = 1'b0;
        bus.clear_c   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out_last", {63'd0, bus.out_last}, 64'd0);
        chk("rst_r_w", {63'd0, bus.tpu_r_w}, 64'd0);
        chk("rst_addr", {48'd0, bus.tpu_addr}, 64'd0);
        chk("rst_wdata", bus.tpu_wdata, 64'd0);
        @(posedge clk) #1;
        rst = 1'b0;
        @(posedge clk) #1;

        // Reset mid-LOAD_B.
        begin
            int beat_in = 0;
            bus.start   = 1'b1;
            bus.clear_c = 1'b1;
            @(posedge clk) #1;
            bus.start = 1'b0;
            while (beat_in < 11) begin
                bus.in_valid = 1'b1;
                bus.in_data  = (beat_in < 8) ? a_rows[beat_in % 8] : b_rows[beat_in % 8];
                @(posedge clk) #1;
                beat_in++;
            end
            bus.in_valid = 1'b1;
            rst = 1'b1;
            @(negedge clk);
            chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
            chk("midrst_r_w", {63'd0, bus.tpu_r_w}, 64'd0);
            chk("midrst_addr", {48'd0, bus.tpu_addr}, 64'd0);
            chk("midrst_in_ready", {63'd0, bus.in_ready}, 64'd0);
            bus.in_valid = 1'b0;
            @(posedge clk) #1;
            rst = 1'b0;
            @(posedge clk) #1;
        end

        // Identity x all-2s with clear: 2s everywhere, done at cycle 74.
        run_job(1'b1, 1'b0, -1, 0, 1'b0, 74, 64'h0002_0002_0002_0002);
        // Accumulate once more without clear: 4s, done at cycle 58.
        run_job(1'b0, 1'b0, -1, 0, 1'b0, 58, 64'h0004_0004_0004_0004);
        // in_valid toggling: 16 extra cycles, writes in order.
        run_job(1'b1, 1'b1, -1, 0, 1'b0, 90, 64'h0002_0002_0002_0002);
        chk("load_write_count", 64'(wr_log.size()), 64'd16);
        for (int i = 0; i < 16 && i < wr_log.size(); i++)
            chk("load_write_addr", {48'd0, wr_log[i]},
                (i < 8) ? 64'(16'h0100 + 8 * i) : 64'(16'h0200 + 8 * (i - 8)));
        // out_ready low for 5 cycles at beat 3.
        run_job(1'b1, 1'b0, 3, 5, 1'b0, 79, 64'h0002_0002_0002_0002);
        // start pulsed during WAIT is ignored.
        run_job(1'b1, 1'b0, -1, 0, 1'b1, 74, 64'h0002_0002_0002_0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tpu_job_sequencer.md
# tpu_job_sequencer

Host-side job sequencer for the 8x8 TPU core. It accepts a single-beat job command and streams 8 A rows and 8 B rows from an input valid/ready stream into the TPU's memory-mapped port. It optionally zeroes the C accumulators, issues the matmul start command, and waits out the systolic computation. It then reads the 16 C half-rows back out on an output valid/ready stream. It sits between the DMA/host fabric and the TPU's addr/r_w/dataIn/dataOut port and is that port's only master.

## Interface
- DIM, 8, systolic dimension; the address map below is fixed for DIM=8.
- DATAW, 64, TPU data width; one A/B row or one C half-row per beat.
- ADDRW, 16, TPU address width.
- WAIT_CYCLES, 3*DIM, idle cycles after the start command before C is read.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  job request; accepted only in IDLE.
- clear_c  in  1  sampled with an accepted start; 1 = zero C before compute.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at job completion.
- in_valid / in_ready  in / out  1 / 1  input stream handshake.
- in_data  in  DATAW  A rows then B rows, row 0 first.
- out_valid / out_ready  out / in  1 / 1  output stream handshake.
- out_data  out  DATAW  C half-row; out_last is high on beat 15.
- out_last  out  1  final output beat.
- tpu_addr  out  ADDRW  TPU address.
- tpu_r_w  out  1  1 = write / command.
- tpu_wdata  out  DATAW  TPU write data.
- tpu_rdata  in  DATAW  TPU read data, combinational from tpu_addr.

## Operation
- States:
  - IDLE -> LOAD_A -> LOAD_B -> (CLR_C if clear_c) -> START -> WAIT -> READ_C -> DONE -> IDLE.
- idx: 4-bit beat counter, cleared on every state entry.
- IDLE
  - tpu_addr=0, tpu_r_w=0, in_ready=0, out_valid=0.
  - start=1 latches clear_c and moves to LOAD_A.
- LOAD_A
  - in_ready=1; tpu_addr=0x0100|idx<<3; tpu_wdata=in_data; tpu_r_w=in_valid.
  - idx increments on each handshake; after the handshake at idx=7, moves to LOAD_B.
- LOAD_B
  - Same as LOAD_A with base 0x0200.
  - After idx=7, moves to CLR_C if clear_c is latched, otherwise to START.
- CLR_C
  - tpu_addr=0x0300|idx<<3; tpu_wdata=0; tpu_r_w=1.
  - 16 unconditional cycles (idx 0..15), then START.
- START
  - One cycle with tpu_addr=0x0400 and tpu_r_w=1, then WAIT.
- WAIT
  - tpu_addr=0, tpu_r_w=0.
  - Counts WAIT_CYCLES cycles, then READ_C.
  - The TPU compute window is 3*DIM-1 cycles starting the cycle after START, so C must not be touched before WAIT exits.
- READ_C
  - tpu_addr=0x0300|idx<<3, giving row=idx[3:1] and half=idx[0]; tpu_r_w=0.
  - out_valid=1; out_data=tpu_rdata; out_last=(idx==15).
  - idx advances on out_ready; tpu_addr is held stable while stalled.
  - After the handshake at idx=15, moves to DONE.
- DONE
  - done=1 for one cycle, then IDLE.
- Bus driving rules:
  - tpu_r_w is never high outside LOAD_A, LOAD_B, CLR_C and START.
  - tpu_addr is 0 in IDLE, WAIT and DONE.
- Input beats arriving outside the LOAD states are not consumed (in_ready=0).
- start while busy is ignored; no queueing.
- Reset
  - Immediate return to IDLE; all outputs go to 0.
  - A TPU computation already started is not cancelled by this block. A matmul in flight at rst completes inside the TPU; software re-runs the job.

## Timing
- Reset values:
  - busy=0, done=0, in_ready=0, out_valid=0, out_last=0.
  - tpu_r_w=0, tpu_addr=0, tpu_wdata=0, out_data=tpu_rdata (don't-care while out_valid=0).
- in_ready, tpu_r_w and tpu_wdata are combinational from the state and in_valid/in_data; the TPU samples them at the same edge as the handshake.
- out_data is combinational from tpu_rdata, with zero-cycle read latency.
- Cycle plan with start at cycle 0, in_valid and out_ready held at 1, clear_c=0:
  - LOAD_A: cycles 1-8.
  - LOAD_B: cycles 9-16.
  - START: cycle 17.
  - WAIT: cycles 18-41.
  - READ_C: cycles 42-57.
  - done: cycle 58.
- clear_c=1 adds 16 cycles (CLR_C occupies cycles 17-32).
- Each cycle of in_valid=0 or out_ready=0 adds exactly one cycle of latency.

## Test plan
- Reset asserted mid-LOAD_B → next cycle: busy=0, tpu_r_w=0, tpu_addr=0. A following job runs normally.
- A=identity, B=all 2s, clear_c=1, streams always ready → 16 output beats, each 0x0002000200020002; out_last only on beat 16; done at cycle 74.
- Same job with clear_c=0, run twice without clearing → second job's beats are all 0x0004000400040004.
- in_valid toggled 1/0 each cycle during LOAD → exactly 16 TPU writes, at addresses 0x0100..0x0138 then 0x0200..0x0238 in order; done delayed by 16 cycles.
- out_ready low for 5 cycles at beat 3 → tpu_addr held at 0x0318 and out_data stable throughout; no beat dropped or duplicated.
- start pulsed during WAIT → ignored. Bus monitor sees exactly one 0x0400 write per job, and no 0x03xx access before WAIT completes.
